// File: rtl/aes_ctr_step_fsm_if.sv
// Bundle of request, status and counter-slice access signals for the
// sliced AES-CTR counter incrementer. Port names keep their direction
// suffixes as seen from the incrementer (the slave side).
interface aes_ctr_step_fsm_if #(
  parameter int SliceSize = 16,
  parameter int NumSlices = 8
);
  localparam int SliceIdxW = $clog2(NumSlices);

  // Request handshake: incr_i is a start request, taken on a rising clock
  // edge only while ready_o=1. step_i and active_slices_i are sampled on that
  // same edge, so they may change freely afterwards. No request is queued:
  // incr_i seen while ready_o=0 has no effect. done_o pulses for one cycle
  // on the final slice write of an accepted request.
  logic                  incr_i;
  logic [SliceSize-1:0]  step_i;
  logic [SliceIdxW:0]    active_slices_i;
  logic                  ready_o;
  logic                  done_o;
  logic                  overflow_o;

  // Error inputs and fatal alert
  logic                  incr_err_i;
  logic                  mr_err_i;
  logic                  alert_o;

  // Counter slice read/modify/write port
  logic [SliceIdxW-1:0]  ctr_slice_idx_o;
  logic [SliceSize-1:0]  ctr_slice_i;
  logic [SliceSize-1:0]  ctr_slice_o;
  logic                  ctr_we_o;

  // Raw FSM state encoding, for observation only
  logic [5:0]            state_dbg;

  modport slave (
    input  incr_i, step_i, active_slices_i, incr_err_i, mr_err_i, ctr_slice_i,
    output ready_o, done_o, overflow_o, alert_o, ctr_slice_idx_o, ctr_slice_o,
           ctr_we_o, state_dbg
  );

  modport master (
    output incr_i, step_i, active_slices_i, incr_err_i, mr_err_i, ctr_slice_i,
    input  ready_o, done_o, overflow_o, alert_o, ctr_slice_idx_o, ctr_slice_o,
           ctr_we_o, state_dbg
  );
endinterface

// File: rtl/aes_ctr_step_fsm.sv
// Sliced counter incrementer for AES-CTR: adds a step to the low slice of a
// NumSlices*SliceSize counter held outside this block, then ripples the carry
// through higher slices one slice per cycle, writing each slice back. Only the
// lowest n slices are touched, giving a mod 2^(n*SliceSize) wrap.
module aes_ctr_step_fsm #(
  parameter int SliceSize = 16,
  parameter int NumSlices = 8,
  parameter bit EarlyExit = 1'b0,
  localparam int SliceIdxW = $clog2(NumSlices)
) (
  input logic              clk_i,
  input logic              rst_ni,
  aes_ctr_step_fsm_if.slave bus
);

  // Sparse encoding: every pair of legal states differs in at least 3 bits,
  // so a single upset cannot turn one legal state into another.
  typedef enum logic [5:0] {
    IDLE  = 6'b010110,
    INCR  = 6'b101100,
    ERROR = 6'b111001
  } state_e;

  localparam logic [SliceIdxW:0]   NumSlicesW = (SliceIdxW+1)'(NumSlices);
  localparam logic [SliceIdxW:0]   NOne       = (SliceIdxW+1)'(1);
  localparam logic [SliceIdxW-1:0] IdxOne     = SliceIdxW'(1);

  state_e                state_q, state_d;
  logic [SliceSize-1:0]  step_q;
  logic [SliceIdxW-1:0]  idx_q;
  logic [SliceIdxW:0]    n_q;
  logic                  carry_q;
  logic                  overflow_q;

  logic [SliceIdxW:0]    n_sel;
  logic [SliceSize-1:0]  addend;
  logic [SliceSize:0]    sum;
  logic                  carry_out;
  logic                  last;
  logic                  ready;
  logic                  done;
  logic                  we;
  logic                  alert;
  logic                  start;

  // Slice adder, completion detect and clamping of the requested slice count
  always_comb begin
    addend = step_q;
    if (idx_q != '0) begin
      addend = {{(SliceSize-1){1'b0}}, carry_q};
    end
    sum       = {1'b0, bus.ctr_slice_i} + {1'b0, addend};
    carry_out = sum[SliceSize];
    last      = ({1'b0, idx_q} == (n_q - NOne)) || (EarlyExit && !carry_out);
    // 0 and out-of-range counts both mean "whole counter"
    n_sel = bus.active_slices_i;
    if (n_sel == '0 || n_sel > NumSlicesW) begin
      n_sel = NumSlicesW;
    end
  end

  // FSM next state and outputs; error inputs win over everything else
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    we      = 1'b0;
    alert   = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.incr_i) begin
          start   = 1'b1;
          state_d = INCR;
        end
      end
      INCR: begin
        we = 1'b1;
        if (last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      ERROR: begin
        alert = 1'b1;
      end
      default: begin
        alert   = 1'b1;
        state_d = ERROR;
      end
    endcase
    if (bus.incr_err_i || bus.mr_err_i) begin
      state_d = ERROR;
      start   = 1'b0;
      done    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation context: latched at acceptance, advanced on every slice write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q     <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (start) begin
      step_q  <= bus.step_i;
      idx_q   <= '0;
      n_q     <= n_sel;
      carry_q <= 1'b0;
    end else if (done) begin
      // Early exit only happens with carry_out=0, so this is also the
      // required "no overflow" value in that case.
      idx_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= carry_out;
    end else if (we) begin
      idx_q   <= idx_q + IdxOne;
      carry_q <= carry_out;
    end
  end

  assign bus.ready_o         = ready;
  assign bus.done_o          = done;
  assign bus.ctr_we_o        = we;
  assign bus.alert_o         = alert;
  assign bus.overflow_o      = overflow_q;
  assign bus.ctr_slice_idx_o = idx_q;
  assign bus.ctr_slice_o     = sum[SliceSize-1:0];
  assign bus.state_dbg       = state_q;

  // Without an alert the FSM must be in one of its operating states
  a_alert_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !bus.alert_o |-> (state_q == IDLE || state_q == INCR));

endmodule

// File: tb/tb_aes_ctr_step_fsm.sv
// Directed bench for aes_ctr_step_fsm with SliceSize=16, NumSlices=8.
// dut0 runs without early exit, dut1 with early exit. Each has a small
// counter memory behind its slice port; expected slice writes are queued
// when a request is issued and popped as the DUT writes.
module tb_aes_ctr_step_fsm;
  localparam int W = 19;  // {idx[2:0], data[15:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [15:0]  mem0[8];
  logic [15:0]  mem1[8];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  logic        ld_en = 1'b0;
  logic        ld_sel = 1'b0;
  logic [2:0]  ld_idx = '0;
  logic [15:0] ld_val = '0;

  aes_ctr_step_fsm_if #(.SliceSize(16), .NumSlices(8)) bus0 ();
  aes_ctr_step_fsm_if #(.SliceSize(16), .NumSlices(8)) bus1 ();

  aes_ctr_step_fsm #(.SliceSize(16), .NumSlices(8), .EarlyExit(1'b0)) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus0.slave)
  );

  aes_ctr_step_fsm #(.SliceSize(16), .NumSlices(8), .EarlyExit(1'b1)) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus1.slave)
  );

  // clock
  always #5 clk = ~clk;

  assign bus0.ctr_slice_i = mem0[bus0.ctr_slice_idx_o];
  assign bus1.ctr_slice_i = mem1[bus1.ctr_slice_idx_o];

  // counter memories: DUT writes plus bench preloads
  always @(posedge clk) begin
    if (bus0.ctr_we_o) mem0[bus0.ctr_slice_idx_o] <= bus0.ctr_slice_o;
    if (bus1.ctr_we_o) mem1[bus1.ctr_slice_idx_o] <= bus1.ctr_slice_o;
    if (ld_en) begin
      if (ld_sel) mem1[ld_idx] <= ld_val;
      else        mem0[ld_idx] <= ld_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every slice write must match the head of the expected queue
  always @(negedge clk) begin
    if (bus0.ctr_we_o) begin
      chk("wr0_pending", 32'(exp_q0.size() != 0), 1);
      if (exp_q0.size() != 0) chk("wr0", {bus0.ctr_slice_idx_o, bus0.ctr_slice_o}, exp_q0.pop_front());
    end
    if (bus1.ctr_we_o) begin
      chk("wr1_pending", 32'(exp_q1.size() != 0), 1);
      if (exp_q1.size() != 0) chk("wr1", {bus1.ctr_slice_idx_o, bus1.ctr_slice_o}, exp_q1.pop_front());
    end
  end

  function automatic logic rdy(input int sel);
    return sel != 0 ? bus1.ready_o : bus0.ready_o;
  endfunction
  function automatic logic dn(input int sel);
    return sel != 0 ? bus1.done_o : bus0.done_o;
  endfunction
  function automatic logic wen(input int sel);
    return sel != 0 ? bus1.ctr_we_o : bus0.ctr_we_o;
  endfunction
  function automatic logic ovf_o(input int sel);
    return sel != 0 ? bus1.overflow_o : bus0.overflow_o;
  endfunction
  function automatic int qsize(input int sel);
    return sel != 0 ? exp_q1.size() : exp_q0.size();
  endfunction

  task automatic drive(input int sel, input logic incr, input logic [15:0] step, input logic [3:0] act);
    if (sel != 0) begin
      bus1.incr_i = incr; bus1.step_i = step; bus1.active_slices_i = act;
    end else begin
      bus0.incr_i = incr; bus0.step_i = step; bus0.active_slices_i = act;
    end
  endtask

  task automatic preload(input int sel, input int idx, input logic [15:0] val);
    ld_en = 1'b1; ld_sel = (sel != 0); ld_idx = 3'(idx); ld_val = val;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // reference: ripple the step through the lowest n slices of the memory
  task automatic model(input int sel, input logic [15:0] step, input logic [3:0] act, output logic ovf);
    logic [15:0] m[8];
    logic [16:0] sum;
    logic        c;
    int          n;
    for (int i = 0; i < 8; i++) m[i] = (sel != 0) ? mem1[i] : mem0[i];
    n = (act == 0 || act > 8) ? 8 : int'(act);
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      sum = {1'b0, m[i]} + ((i == 0) ? {1'b0, step} : {16'b0, c});
      if (sel != 0) exp_q1.push_back({3'(i), sum[15:0]});
      else          exp_q0.push_back({3'(i), sum[15:0]});
      c = sum[16];
      if (sel != 0 && !c) break;
    end
    ovf = c;
  endtask

  // one request: hold keeps incr high afterwards, cont means the bench is
  // already at the idle-cycle sample point of a held previous request
  task automatic run_op(input int sel, input logic [15:0] step, input logic [3:0] act,
                        input bit hold, input bit cont, input int exp_lat);
    logic ovf;
    int   cyc;
    model(sel, step, act, ovf);
    if (!cont) @(negedge clk);
    chk("ready_pre", rdy(sel), 1);
    drive(sel, 1'b1, step, act);
    @(posedge clk);
    #1 if (!hold) drive(sel, 1'b0, 16'h0, 4'h0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dn(sel) && cyc < 40);
    chk("latency", cyc, exp_lat);
    @(negedge clk);
    chk("ready_post", rdy(sel), 1);
    chk("done_post", dn(sel), 0);
    chk("we_post", wen(sel), 0);
    chk("overflow", ovf_o(sel), ovf);
    chk("queue_empty", qsize(sel), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ovf;
    logic [15:0] old;
    int          cyc;
    drive(0, 1'b0, 16'h0, 4'h0);
    drive(1, 1'b0, 16'h0, 4'h0);
    bus0.incr_err_i = 1'b0; bus0.mr_err_i = 1'b0;
    bus1.incr_err_i = 1'b0; bus1.mr_err_i = 1'b0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus0.ready_o, 1);
    chk("rst_done", bus0.done_o, 0);
    chk("rst_we", bus0.ctr_we_o, 0);
    chk("rst_alert", bus0.alert_o, 0);
    chk("rst_ovf", bus0.overflow_o, 0);
    chk("rst_idx", bus0.ctr_slice_idx_o, 0);
    chk("rst_alert1", bus1.alert_o, 0);
    rst_n = 1'b1;

    // full 128-bit wrap: all ones + 1
    for (int i = 0; i < 8; i++) preload(0, i, 16'hFFFF);
    run_op(0, 16'h0001, 4'd8, 1'b0, 1'b0, 8);
    chk("wrap_ovf", bus0.overflow_o, 1);
    chk("wrap_mem7", mem0[7], 16'h0000);

    // reset during slice 4
    for (int i = 0; i < 8; i++) preload(0, i, 16'hFFFF);
    model(0, 16'h0001, 4'd8, ovf);
    @(negedge clk);
    drive(0, 1'b1, 16'h0001, 4'd8);
    @(posedge clk);
    #1 drive(0, 1'b0, 16'h0, 4'h0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus0.ctr_slice_idx_o != 3'd4 && cyc < 40);
    chk("rst_mid_idx4", bus0.ctr_slice_idx_o, 4);
    #1 rst_n = 1'b0;
    chk("rst_mid_left", exp_q0.size(), 3);
    exp_q0.delete();
    #1;
    chk("rst_mid_ready", bus0.ready_o, 1);
    chk("rst_mid_idx", bus0.ctr_slice_idx_o, 0);
    chk("rst_mid_ovf", bus0.overflow_o, 0);
    chk("rst_mid_we", bus0.ctr_we_o, 0);
    repeat (2) @(negedge clk);
    chk("rst_mid_mem4", mem0[4], 16'hFFFF);
    chk("rst_mid_mem3", mem0[3], 16'h0000);
    rst_n = 1'b1;
    run_op(0, 16'h0003, 4'd4, 1'b0, 1'b0, 4);

    // n=2 wrap leaves slice 2 alone
    preload(0, 0, 16'hFFFF); preload(0, 1, 16'hFFFF); preload(0, 2, 16'h1234);
    run_op(0, 16'h0001, 4'd2, 1'b0, 1'b0, 2);
    chk("n2_ovf", bus0.overflow_o, 1);
    chk("n2_mem2", mem0[2], 16'h1234);

    // count 0 and count > NumSlices both cover all 8 slices
    for (int i = 0; i < 8; i++) preload(0, i, 16'($urandom_range(0, 65535)));
    run_op(0, 16'($urandom_range(0, 65535)), 4'd0, 1'b0, 1'b0, 8);
    for (int i = 0; i < 8; i++) preload(0, i, 16'($urandom_range(0, 65535)));
    run_op(0, 16'($urandom_range(1, 65535)), 4'd12, 1'b0, 1'b0, 8);

    // step 0 rewrites unchanged
    old = mem0[0];
    run_op(0, 16'h0000, 4'd3, 1'b0, 1'b0, 3);
    chk("step0_mem0", mem0[0], old);
    chk("step0_ovf", bus0.overflow_o, 0);

    // incr held high: one operation, next only once back in IDLE
    for (int i = 0; i < 8; i++) preload(0, i, 16'hFFFF);
    run_op(0, 16'h0001, 4'd8, 1'b1, 1'b0, 8);
    run_op(0, 16'h0001, 4'd8, 1'b0, 1'b1, 8);
    repeat (3) begin
      @(negedge clk);
      chk("hold_quiet", bus0.ctr_we_o, 0);
    end
    chk("hold_mem0", mem0[0], 16'h0001);

    // early exit variants
    preload(1, 0, 16'h0001);
    run_op(1, 16'h0005, 4'd8, 1'b0, 1'b0, 1);
    chk("ee_mem0", mem1[0], 16'h0006);
    chk("ee_ovf", bus1.overflow_o, 0);
    preload(1, 0, 16'hFFFF); preload(1, 1, 16'hFFFF); preload(1, 2, 16'h0005);
    run_op(1, 16'h0001, 4'd8, 1'b0, 1'b0, 3);
    for (int i = 0; i < 8; i++) preload(1, i, 16'hFFFF);
    run_op(1, 16'h0001, 4'd8, 1'b0, 1'b0, 8);
    chk("ee_full_ovf", bus1.overflow_o, 1);

    // mr_err during slice 3
    for (int i = 0; i < 8; i++) preload(0, i, 16'hFFFF);
    model(0, 16'h0001, 4'd8, ovf);
    @(negedge clk);
    drive(0, 1'b1, 16'h0001, 4'd8);
    @(posedge clk);
    #1 drive(0, 1'b0, 16'h0, 4'h0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus0.ctr_slice_idx_o != 3'd3 && cyc < 40);
    chk("err_idx3", bus0.ctr_slice_idx_o, 3);
    bus0.mr_err_i = 1'b1;
    @(negedge clk);
    bus0.mr_err_i = 1'b0;
    chk("err_alert", bus0.alert_o, 1);
    chk("err_we", bus0.ctr_we_o, 0);
    chk("err_ready", bus0.ready_o, 0);
    chk("err_left", exp_q0.size(), 4);
    exp_q0.delete();
    drive(0, 1'b1, 16'h0001, 4'd8);
    repeat (4) begin
      @(negedge clk);
      chk("err_hold_alert", bus0.alert_o, 1);
      chk("err_hold_we", bus0.ctr_we_o, 0);
      chk("err_hold_done", bus0.done_o, 0);
    end
    chk("err_mem4", mem0[4], 16'hFFFF);
    drive(0, 1'b0, 16'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("err_rst_alert", bus0.alert_o, 0);
    chk("err_rst_ready", bus0.ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // incr_err in IDLE
    @(negedge clk);
    bus0.incr_err_i = 1'b1;
    @(negedge clk);
    bus0.incr_err_i = 1'b0;
    chk("ierr_alert", bus0.alert_o, 1);
    chk("ierr_ready", bus0.ready_o, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ierr_rst_alert", bus0.alert_o, 0);
    rst_n = 1'b1;
    run_op(0, 16'h0002, 4'd1, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_ctr_step_fsm.md
AES_CTR_STEP_FSM -- requirements
Module: aes_ctr_step_fsm

Interface
REQ-001 The block SHALL provide parameter SliceSize, default 16, meaning the number of counter bits processed per cycle.
REQ-002 The block SHALL provide parameter NumSlices, default 8, meaning the slices in the full counter (128 bit); SliceIdxW = clog2(NumSlices) SHALL be derived.
REQ-003 The block SHALL provide parameter EarlyExit, default 0, meaning that 1 enables termination on zero carry-out.
REQ-004 The block SHALL provide clk_i, input, 1, the single clock.
REQ-005 The block SHALL provide rst_ni, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL provide incr_i, input, 1, the start request, accepted only when ready_o=1.
REQ-007 The block SHALL provide step_i, input, SliceSize, the increment amount, sampled at start.
REQ-008 The block SHALL provide active_slices_i, input, SliceIdxW+1, giving the slices affected (wrap width), sampled at start.
REQ-009 The block SHALL provide ready_o, output, 1, asserted to mean idle and able to accept.
REQ-010 The block SHALL provide done_o, output, 1, a one-cycle completion pulse.
REQ-011 The block SHALL provide overflow_o, output, 1, meaning carry out of the top active slice on the last operation.
REQ-012 The block SHALL provide incr_err_i and mr_err_i, input, 1 each, as error indications.
REQ-013 The block SHALL provide alert_o, output, 1, meaning fatal error.
REQ-014 The block SHALL provide ctr_slice_idx_o, output, SliceIdxW, the current slice index.
REQ-015 The block SHALL provide ctr_slice_i, input, SliceSize, the current slice value read back.
REQ-016 The block SHALL provide ctr_slice_o, output, SliceSize, the updated slice value.
REQ-017 The block SHALL provide ctr_we_o, output, 1, the write enable for ctr_slice_o at ctr_slice_idx_o.

Function
REQ-018 The FSM states SHALL be IDLE, INCR and ERROR, with sparse encoding via the codebase's sparse-FSM flop primitive and IDLE as the reset state.
REQ-019 In IDLE, ready_o SHALL be 1; incr_i=1 SHALL latch step_i, set idx=0, set n=active_slices_i (0 or >NumSlices treated as NumSlices), and move to INCR.
REQ-020 In INCR, slice idx 0 SHALL compute ctr_slice_i+step; each slice idx>0 SHALL compute ctr_slice_i+carry_q; the SliceSize+1-bit sum SHALL have its low bits drive ctr_slice_o and its MSB register into carry_q.
REQ-021 In INCR, ctr_we_o SHALL be 1 in every cycle and idx SHALL increment by 1 per cycle, LSB slice first.
REQ-022 Completion SHALL occur when idx==n-1, or when EarlyExit=1 and the current carry-out is 0; on completion done_o SHALL be 1 in that same cycle (the last write) and the next state SHALL be IDLE.
REQ-023 Latency SHALL be n cycles from acceptance to done_o (EarlyExit=0), and SHALL be 1..n cycles (EarlyExit=1).
REQ-024 overflow_o SHALL be registered at completion with the carry-out of slice n-1 (0 if exited early) and held until the next completion.
REQ-025 Slices >= n SHALL never be written (mod 2^(n*SliceSize) wrap, e.g. GCM inc32 with n=2 at SliceSize=16).
REQ-026 step_i=0 SHALL be legal: slice 0 is rewritten unchanged with carry 0.
REQ-027 incr_i in INCR or ERROR SHALL be ignored, and no queuing SHALL occur.
REQ-028 incr_err_i or mr_err_i SHALL, in any state, force next state ERROR; this SHALL override completion.
REQ-029 In ERROR, alert_o SHALL be 1, ready_o/done_o/ctr_we_o SHALL be 0, and the block SHALL remain in ERROR until reset.
REQ-030 Any invalid state encoding SHALL cause alert_o=1 in that cycle and a move to ERROR.
REQ-031 An assertion SHALL check that alert_o=0 implies the state is IDLE or INCR.

Reset
REQ-032 Asynchronous reset SHALL force state IDLE, idx=0, carry_q=0, step=0, n=0, overflow_o=0; ready_o SHALL be 1 and done_o/ctr_we_o/alert_o SHALL be 0.
REQ-033 Reset mid-INCR SHALL abandon the operation immediately, with no further writes.

Verification (SliceSize=16, NumSlices=8)
REQ-034 The bench SHALL check: EarlyExit=0, all slices 0xFFFF, step 1, n=8 -> 8 writes of 0x0000 at idx 0..7, done_o in 8th cycle, overflow_o=1.
REQ-035 The bench SHALL check: n=2, slices 0,1 = 0xFFFF, slice 2 = 0x1234, step 1 -> 2 writes of 0x0000, slice 2 untouched, overflow_o=1.
REQ-036 The bench SHALL check: EarlyExit=1, slice0=0x0001, step 5, n=8 -> single write 0x0006 at idx 0, done_o same cycle, overflow_o=0, ready_o next cycle.
REQ-037 The bench SHALL check: mr_err_i pulsed during idx 3 -> ERROR next cycle, alert_o=1, ctr_we_o=0, incr_i ignored, held until rst_ni low.
REQ-038 The bench SHALL check: rst_ni low during idx 4 -> ready_o=1, ctr_slice_idx_o=0, overflow_o=0, no writes; a new request then runs normally.
REQ-039 The bench SHALL check: incr_i held high through an 8-cycle operation -> exactly one operation, then a second accepted only after returning to IDLE.
